// File: rtl/frame_config_loader.sv
`timescale 1ns/1ps
// frame_config_loader: parses the synchronised configuration word stream into
// full-frame FrameData writes plus a single one-cycle FrameStrobe pulse per frame.
module frame_config_loader #(
  parameter int          FABRIC_NUM_COLUMNS = 4,
  parameter int          FABRIC_NUM_ROWS    = 5,
  parameter int          FRAMES_PER_COLUMN  = 20,
  parameter logic [31:0] SYNC_WORD          = 32'hFAB0_FAB1
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic [31:0]                                  bitstream_data_i,
  input  logic                                         bitstream_valid_i,
  output logic [32*FABRIC_NUM_ROWS-1:0]                frame_data_o,
  output logic [FABRIC_NUM_COLUMNS*FRAMES_PER_COLUMN-1:0] frame_strobe_o,
  output logic                                         busy_o,
  output logic                                         configured_o,
  output logic                                         error_o
);

  localparam int NSTB = FABRIC_NUM_COLUMNS * FRAMES_PER_COLUMN;
  localparam int IDXW = (NSTB > 1) ? $clog2(NSTB) : 1;
  localparam int ROWW = (FABRIC_NUM_ROWS > 1) ? $clog2(FABRIC_NUM_ROWS) : 1;

  localparam logic [7:0] OP_FRAME = 8'h01;
  localparam logic [7:0] OP_END   = 8'hFF;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_ERROR} state_e;

  state_e                              state_q, state_d;
  logic [IDXW-1:0]                     idx_q, idx_d;
  logic [ROWW-1:0]                     row_q, row_d;
  logic [FABRIC_NUM_ROWS-1:0][31:0]    data_q, data_d;
  logic [NSTB-1:0]                     strobe_q, strobe_d;
  logic                                cfg_q, cfg_d;
  logic                                err_q, err_d;
  logic                                busy_q, busy_d;

  logic [7:0]      opcode;
  logic [7:0]      hdr_col;
  logic [7:0]      hdr_frm;
  logic            hdr_ok;
  logic [IDXW-1:0] hdr_idx;
  logic            is_sync;

  assign opcode  = bitstream_data_i[31:24];
  assign hdr_col = bitstream_data_i[23:16];
  assign hdr_frm = bitstream_data_i[7:0];
  assign is_sync = (bitstream_data_i == SYNC_WORD);
  // Range check on the raw 8-bit fields, so the narrow index math below never
  // sees an out-of-range address.
  assign hdr_ok  = (32'(hdr_col) < FABRIC_NUM_COLUMNS) &&
                   (32'(hdr_frm) < FRAMES_PER_COLUMN);
  assign hdr_idx = IDXW'(hdr_col) * IDXW'(FRAMES_PER_COLUMN) + IDXW'(hdr_frm);

  // Next-state, frame assembly and status decode.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    row_d    = row_q;
    data_d   = data_q;
    strobe_d = '0;
    cfg_d    = cfg_q;
    err_d    = err_q;
    if (bitstream_valid_i) begin
      unique case (state_q)
        S_IDLE, S_ERROR: begin
          if (is_sync) begin
            state_d = S_HEADER;
            cfg_d   = 1'b0;
            err_d   = 1'b0;
          end
        end
        S_HEADER: begin
          if (is_sync) begin
            state_d = S_HEADER;
          end else if (opcode == OP_FRAME) begin
            if (hdr_ok) begin
              idx_d   = hdr_idx;
              row_d   = '0;
              state_d = S_DATA;
            end else begin
              state_d = S_ERROR;
              err_d   = 1'b1;
              cfg_d   = 1'b0;
            end
          end else if (opcode == OP_END) begin
            cfg_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            cfg_d   = 1'b0;
          end
        end
        S_DATA: begin
          // Data words are literal; a SYNC_WORD value here is just row data.
          data_d[row_q] = bitstream_data_i;
          if (row_q == ROWW'(FABRIC_NUM_ROWS - 1)) begin
            strobe_d[idx_q] = 1'b1;
            state_d         = S_HEADER;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_HEADER) || (state_d == S_DATA);
  end

  // State and output registers; reset abandons any partial frame at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      row_q    <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      cfg_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      cfg_q    <= cfg_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign frame_data_o   = data_q;
  assign frame_strobe_o = strobe_q;
  assign busy_o         = busy_q;
  assign configured_o   = cfg_q;
  assign error_o        = err_q;

endmodule

// File: tb/tb_frame_config_loader.sv
`timescale 1ns/1ps
// Bench for frame_config_loader: packet-level reference model checked every
// cycle, plus directed literal expectations per scenario.
module tb_frame_config_loader;
  localparam int C = 4, R = 5, F = 20, N = C * F;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      din = '0;
  logic             vld = 1'b0;
  logic [32*R-1:0]  fdata;
  logic [N-1:0]     fstb;
  logic             busy, cfg, err;

  always #5 clk = ~clk;

  frame_config_loader #(
    .FABRIC_NUM_COLUMNS(C), .FABRIC_NUM_ROWS(R),
    .FRAMES_PER_COLUMN(F), .SYNC_WORD(SYNC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .bitstream_data_i(din), .bitstream_valid_i(vld),
    .frame_data_o(fdata), .frame_strobe_o(fstb),
    .busy_o(busy), .configured_o(cfg), .error_o(err)
  );

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "synced" means a header or data word is expected,
  // "left" counts data words still owed to the current frame.
  bit               m_sync, m_err, m_cfg;
  int               m_left, m_col, m_fr;
  logic [R-1:0][31:0] m_data;
  logic [N-1:0]     m_stb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync = 0; m_err = 0; m_cfg = 0; m_left = 0; m_col = 0; m_fr = 0;
      m_data = '0; m_stb = '0;
    end else begin
      m_stb = '0;
      if (vld) begin
        if (!m_sync) begin
          if (din == SYNC) begin m_sync = 1; m_err = 0; m_cfg = 0; m_left = 0; end
        end else if (m_left > 0) begin
          m_data[R - m_left] = din;
          m_left--;
          if (m_left == 0) m_stb[m_col * F + m_fr] = 1'b1;
        end else if (din != SYNC) begin
          if (din[31:24] == 8'h01) begin
            if (int'(din[23:16]) < C && int'(din[7:0]) < F) begin
              m_col = int'(din[23:16]); m_fr = int'(din[7:0]); m_left = R;
            end else begin
              m_err = 1; m_sync = 0; m_cfg = 0;
            end
          end else if (din[31:24] == 8'hFF) begin
            m_cfg = 1; m_sync = 0;
          end else begin
            m_err = 1; m_sync = 0; m_cfg = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus strobe pulse accounting.
  int hits[N];
  int pulses = 0;
  always @(negedge clk) begin
    chk("frame_data", fdata, m_data);
    chk("frame_strobe", 160'(fstb), 160'(m_stb));
    chk("busy", 160'(busy), 160'(m_sync));
    chk("configured", 160'(cfg), 160'(m_cfg));
    chk("error", 160'(err), 160'(m_err));
    for (int i = 0; i < N; i++) if (fstb[i]) hits[i]++;
    if (|fstb) pulses++;
  end

  int b_hits[N];
  int b_pulses;
  task automatic snap();
    b_hits = hits;
    b_pulses = pulses;
  endtask

  task automatic send(input logic [31:0] w, input int gap);
    @(posedge clk); #1;
    din = w; vld = 1'b1;
    repeat (gap) begin @(posedge clk); #1; vld = 1'b0; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; vld = 1'b0; end
  endtask

  task automatic frame(input logic [31:0] hdr, input logic [31:0] base);
    send(hdr, 0);
    for (int k = 0; k < R; k++) send(base + 32'(k), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) hits[i] = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", 160'(busy), 160'(0));
    chk("reset_data", fdata, 160'(0));
    @(negedge clk); rst_n = 1'b1;

    // 1: garbage, SYNC, frame col 2 / fr 5.
    snap();
    send(32'h1234_5678, 1); send(32'h0102_0005, 0); send(32'hFFFF_FFFF, 2);
    send(SYNC, 0); send(32'h0102_0005, 0);
    send(32'h1111_1111, 0); send(32'h2222_2222, 0); send(32'h3333_3333, 0);
    send(32'h4444_4444, 0); send(32'h5555_5555, 0);
    idle(3);
    chk("t1_data", fdata, 160'h55555555_44444444_33333333_22222222_11111111);
    chk("t1_hit45", 160'(hits[45] - b_hits[45]), 160'(1));
    chk("t1_pulses", 160'(pulses - b_pulses), 160'(1));
    chk("t1_busy", 160'(busy), 160'(1));

    // 2: two frames back to back, then END.
    snap();
    frame(32'h0100_0000, 32'hA000_0000);
    frame(32'h0103_0013, 32'hB000_0000);
    send(32'hFF00_0000, 0);
    idle(2);
    chk("t2_hit0", 160'(hits[0] - b_hits[0]), 160'(1));
    chk("t2_hit79", 160'(hits[79] - b_hits[79]), 160'(1));
    chk("t2_pulses", 160'(pulses - b_pulses), 160'(2));
    chk("t2_cfg", 160'(cfg), 160'(1));
    chk("t2_busy", 160'(busy), 160'(0));

    // 3: out-of-range column, words ignored, then recovery.
    snap();
    send(SYNC, 0); send(32'h0104_0000, 0);
    send(32'hDEAD_BEEF, 0); send(32'h0100_0001, 0); send(32'hFF00_0000, 0);
    idle(2);
    chk("t3_err", 160'(err), 160'(1));
    chk("t3_cfg", 160'(cfg), 160'(0));
    chk("t3_busy", 160'(busy), 160'(0));
    chk("t3_pulses", 160'(pulses - b_pulses), 160'(0));
    send(SYNC, 1);
    chk("t3_err_clr", 160'(err), 160'(0));
    frame(32'h0101_0002, 32'hC000_0000);
    send(32'hFF00_0000, 0);
    idle(2);
    chk("t3_cfg_set", 160'(cfg), 160'(1));
    chk("t3_hit22", 160'(hits[22] - b_hits[22]), 160'(1));

    // 4: SYNC_WORD as row-2 data, random gaps.
    snap();
    send(SYNC, $urandom_range(0, 7));
    send(32'h0100_0007, $urandom_range(0, 7));
    send(32'hD000_0000, $urandom_range(0, 7));
    send(32'hD000_0001, $urandom_range(0, 7));
    send(SYNC, $urandom_range(0, 7));
    send(32'hD000_0003, $urandom_range(0, 7));
    send(32'hD000_0004, $urandom_range(0, 7));
    idle(3);
    chk("t4_row2", 160'(fdata[95:64]), 160'(SYNC));
    chk("t4_hit7", 160'(hits[7] - b_hits[7]), 160'(1));
    chk("t4_pulses", 160'(pulses - b_pulses), 160'(1));

    // 5: reset mid-frame, then data without SYNC.
    snap();
    send(SYNC, 0); send(32'h0102_0003, 0);
    send(32'hE000_0000, 0); send(32'hE000_0001, 0); send(32'hE000_0002, 0);
    idle(1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t5_data0", fdata, 160'(0));
    chk("t5_strobe0", 160'(fstb), 160'(0));
    chk("t5_busy0", 160'(busy), 160'(0));
    chk("t5_cfg0", 160'(cfg), 160'(0));
    chk("t5_err0", 160'(err), 160'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < R; k++) send(32'hE000_0003 + 32'(k), 0);
    idle(3);
    chk("t5_pulses", 160'(pulses - b_pulses), 160'(0));
    chk("t5_busy", 160'(busy), 160'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
